// File: rtl/alu_sched_pkg.sv
// Shared op-code constants and scheduler state encoding for the ALU scheduler
// and anything that talks to it.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [3:0] ctrl);
    return ctrl == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between two requesters, the ALU scheduler and
// its result consumer.
interface alu_sched_if #(
  parameter int DATA_W = 32
);

  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [DATA_W-1:0] req0_data1_i;
  logic [DATA_W-1:0] req0_data2_i;
  logic [3:0]        req0_ctrl_i;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [DATA_W-1:0] req1_data1_i;
  logic [DATA_W-1:0] req1_data2_i;
  logic [3:0]        req1_ctrl_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_id_o;
  logic              rsp_zero_o;
  logic              rsp_err_o;
  logic              busy_o;

  modport slave (
    input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    output req0_ready_o,
    input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    output req1_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_id_o, rsp_zero_o, rsp_err_o, busy_o,
    input  rsp_ready_i
  );

  modport master (
    output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    input  req0_ready_o,
    output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    input  req1_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_id_o, rsp_zero_o, rsp_err_o, busy_o,
    output rsp_ready_i
  );

endinterface

// File: rtl/alu_sched_mul_iter.sv
// Iterative shift-add multiplier keeping only the low DATA_W product bits;
// one step per cycle, the first step taken on the start edge itself.
module mul_iter #(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] product_lo
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  logic [DATA_W-1:0] mcand_reg, mcand_next;
  logic [DATA_W-1:0] mplier_reg, mplier_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]  count_reg;
  logic              run_reg;

  logic [DATA_W-1:0] mcand_src;
  logic [DATA_W-1:0] mplier_src;
  logic [DATA_W-1:0] acc_src;

  // The start edge steps directly on the incoming operands, so a full
  // multiply completes MUL_STEPS edges after start, including that edge.
  always_comb begin
    mcand_src   = start ? op_a : mcand_reg;
    mplier_src  = start ? op_b : mplier_reg;
    acc_src     = start ? '0   : acc_reg;
    acc_next    = mplier_src[0] ? (acc_src + mcand_src) : acc_src;
    mcand_next  = mcand_src << 1;
    mplier_next = mplier_src >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      run_reg    <= 1'b0;
    end else if (start) begin
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      count_reg  <= CNT_W'(MUL_STEPS - 1);
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      if (count_reg != '0) begin
        mcand_reg  <= mcand_next;
        mplier_reg <= mplier_next;
        acc_reg    <= acc_next;
        count_reg  <= count_reg - CNT_W'(1);
      end else begin
        run_reg <= 1'b0;
      end
    end
  end

  assign done       = run_reg && (count_reg == '0);
  assign product_lo = acc_reg;

endmodule

// File: rtl/alu_sched.sv
// Two-requester ALU front end: round-robin arbitration in IDLE, single-cycle
// logic/arith ops, iterative multiply, and a held response slot.
module alu_sched
  import alu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_sched_if.slave   bus
);

  state_t state_reg, state_next;

  logic              rr_reg;
  logic              id_reg;
  logic              err_reg;
  logic [DATA_W-1:0] result_reg;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [DATA_W-1:0]  req_a    [NUM_REQ];
  logic [DATA_W-1:0]  req_b    [NUM_REQ];
  logic [3:0]         req_ctrl [NUM_REQ];

  logic              grant;
  logic              accept;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [3:0]        sel_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_err;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign req_valid   = {bus.req1_valid_i, bus.req0_valid_i};
  assign req_a[0]    = bus.req0_data1_i;
  assign req_b[0]    = bus.req0_data2_i;
  assign req_ctrl[0] = bus.req0_ctrl_i;
  assign req_a[1]    = bus.req1_data1_i;
  assign req_b[1]    = bus.req1_data2_i;
  assign req_ctrl[1] = bus.req1_ctrl_i;

  // Tie between both requesters is broken by rr; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid[1] && (!req_valid[0] || rr_reg)) begin
      grant = 1'b1;
    end
  end

  assign accept = (state_reg == ST_IDLE) && (req_valid != '0);

  // Ready is forced low while reset is asserted, not only after it is sampled.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = rst_i && (state_reg == ST_IDLE) && req_valid[gi]
                             && (grant == gi[0]);
    end
  endgenerate

  assign bus.req0_ready_o = req_ready[0];
  assign bus.req1_ready_o = req_ready[1];

  assign sel_a    = req_a[grant];
  assign sel_b    = req_b[grant];
  assign sel_ctrl = req_ctrl[grant];

  always_comb begin
    alu_result = '0;
    alu_err    = 1'b0;
    case (sel_ctrl)
      OP_ADD:  alu_result = sel_a + sel_b;
      OP_SUB:  alu_result = sel_a - sel_b;
      OP_AND:  alu_result = sel_a & sel_b;
      OP_OR:   alu_result = sel_a | sel_b;
      OP_MUL:  alu_result = '0;
      default: alu_err    = 1'b1;
    endcase
  end

  assign mul_start = accept && is_mul(sel_ctrl);

  mul_iter #(
    .DATA_W    (DATA_W),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .start      (mul_start),
    .op_a       (sel_a),
    .op_b       (sel_b),
    .done       (mul_done),
    .product_lo (mul_product)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // RESP always returns to IDLE first, so no accept shares the handshake edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = is_mul(sel_ctrl) ? ST_MUL : ST_RESP;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_reg     <= 1'b0;
      id_reg     <= 1'b0;
      err_reg    <= 1'b0;
      result_reg <= '0;
    end else if (accept) begin
      rr_reg     <= ~grant;
      id_reg     <= grant;
      err_reg    <= alu_err;
      result_reg <= alu_result;
    end else if ((state_reg == ST_MUL) && mul_done) begin
      result_reg <= mul_product;
    end
  end

  assign bus.rsp_valid_o = (state_reg == ST_RESP);
  assign bus.rsp_data_o  = result_reg;
  assign bus.rsp_id_o    = id_reg;
  assign bus.rsp_err_o   = err_reg;
  assign bus.rsp_zero_o  = (state_reg == ST_RESP) && (result_reg == '0);
  assign bus.busy_o      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed vector table, randomized
// two-requester traffic against an arithmetic model, and a mid-multiply reset.
module tb_alu_sched;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    logic        v0;
    op_t         o0;
    logic        v1;
    op_t         o1;
    int          hold;
    logic        keep;
    logic [31:0] exp_data;
    logic        exp_id;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic rr_m;

  always #5 clk = ~clk;

  alu_sched_if #(.DATA_W(32)) bus ();

  alu_sched #(
    .DATA_W    (32),
    .MUL_STEPS (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result model straight from the op-code table: {err, data}.
  function automatic logic [32:0] model(input op_t o);
    case (o.ctrl)
      4'b0010: return {1'b0, o.a + o.b};
      4'b0110: return {1'b0, o.a - o.b};
      4'b0000: return {1'b0, o.a & o.b};
      4'b0001: return {1'b0, o.a | o.b};
      4'b0011: return {1'b0, o.a * o.b};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic drive_req(input logic v0, input op_t o0, input logic v1, input op_t o1);
    bus.req0_valid_i = v0;
    bus.req0_ctrl_i  = o0.ctrl;
    bus.req0_data1_i = o0.a;
    bus.req0_data2_i = o0.b;
    bus.req1_valid_i = v1;
    bus.req1_ctrl_i  = o1.ctrl;
    bus.req1_data1_i = o1.a;
    bus.req1_data2_i = o1.b;
  endtask

  function automatic op_t junk_op();
    op_t j;
    j.ctrl = 4'($urandom_range(0, 15));
    j.a    = $urandom;
    j.b    = $urandom;
    return j;
  endfunction

  function automatic logic [37:0] rsp_snapshot();
    return {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_err_o, bus.rsp_zero_o,
            bus.req0_ready_o, bus.req1_ready_o, bus.rsp_data_o};
  endfunction

  // Called away from clock edges with the DUT idle; issues one op and
  // consumes its response, keeping junk requests pending while busy.
  task automatic transact(input string name, input vec_t t);
    int          lat;
    logic        ready_seen;
    logic        exp_zero;
    logic [37:0] exp_snap;
    exp_zero = (t.exp_data == 32'h0);
    drive_req(t.v0, t.o0, t.v1, t.o1);
    #1;
    check({name, "_busy_idle"}, 64'(bus.busy_o), 64'(0));
    check({name, "_ready0"}, 64'(bus.req0_ready_o), 64'(t.exp_id == 1'b0));
    check({name, "_ready1"}, 64'(bus.req1_ready_o), 64'(t.exp_id == 1'b1));
    @(posedge clk); #1;
    rr_m = ~t.exp_id;
    drive_req(1'b1, junk_op(), 1'b1, junk_op());
    lat        = 1;
    ready_seen = 1'b0;
    while (!bus.rsp_valid_o && lat < 60) begin
      if (bus.req0_ready_o || bus.req1_ready_o) ready_seen = 1'b1;
      bus.rsp_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    bus.rsp_ready_i = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(t.exp_lat));
    check({name, "_ready_low_busy"}, 64'(ready_seen), 64'(0));
    exp_snap = {1'b1, t.exp_id, t.exp_err, exp_zero, 1'b0, 1'b0, t.exp_data};
    check({name, "_rsp"}, 64'(rsp_snapshot()), 64'(exp_snap));
    repeat (t.hold) begin
      @(posedge clk); #1;
      check({name, "_hold"}, 64'(rsp_snapshot()), 64'(exp_snap));
    end
    if (!t.keep) drive_req(1'b0, junk_op(), 1'b0, junk_op());
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    check({name, "_released"}, 64'({bus.rsp_valid_o, bus.busy_o}), 64'(0));
    if (t.keep) begin
      check({name, "_accept_next"}, 64'(bus.req0_ready_o | bus.req1_ready_o), 64'(1));
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [3:0] c0, input logic [31:0] a0,
                              input logic [31:0] b0, input logic v1, input logic [3:0] c1,
                              input logic [31:0] a1, input logic [31:0] b1, input int hold,
                              input logic keep, input logic [31:0] d, input logic id,
                              input logic err, input int lat);
    vec_t t;
    t.v0 = v0; t.o0.ctrl = c0; t.o0.a = a0; t.o0.b = b0;
    t.v1 = v1; t.o1.ctrl = c1; t.o1.a = a1; t.o1.b = b1;
    t.hold = hold; t.keep = keep;
    t.exp_data = d; t.exp_id = id; t.exp_err = err; t.exp_lat = lat;
    return t;
  endfunction

  vec_t tbl[10];

  initial begin
    vec_t        t;
    op_t         o;
    logic [32:0] m;
    logic [3:0]  codes[6];
    logic        bad_seen;

    // Directed table, applied in order from reset (rr starts at 0).
    tbl[0] = mk(1, 4'b0110, 32'd3, 32'd5, 1, 4'b0000, 32'hFFFF0000, 32'h0F0F0F0F,
                0, 0, 32'hFFFFFFFE, 0, 0, 1);
    tbl[1] = mk(0, 4'b0010, 32'd0, 32'd0, 1, 4'b0000, 32'hFFFF0000, 32'h0F0F0F0F,
                0, 0, 32'h0F0F0000, 1, 0, 1);
    tbl[2] = mk(1, 4'b0010, 32'd5, 32'd7, 0, 4'b0000, 32'd0, 32'd0,
                0, 0, 32'd12, 0, 0, 1);
    tbl[3] = mk(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0011, 32'h00010000, 32'h00010003,
                0, 0, 32'h00030000, 1, 0, 33);
    tbl[4] = mk(1, 4'b1111, 32'd1234, 32'd5, 0, 4'b0000, 32'd0, 32'd0,
                0, 0, 32'h0, 0, 1, 1);
    tbl[5] = mk(1, 4'b0001, 32'h1, 32'h2, 1, 4'b0010, 32'hFFFFFFFF, 32'h1,
                0, 0, 32'h0, 1, 0, 1);
    tbl[6] = mk(1, 4'b0110, 32'd0, 32'd1, 1, 4'b0001, 32'h5, 32'h5,
                0, 0, 32'hFFFFFFFF, 0, 0, 1);
    tbl[7] = mk(1, 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4'b0000, 32'd0, 32'd0,
                10, 1, 32'h00000001, 0, 0, 33);
    tbl[8] = mk(0, 4'b0000, 32'd0, 32'd0, 1, 4'b0001, 32'hF0F00000, 32'h00000F0F,
                0, 0, 32'hF0F00F0F, 1, 0, 1);
    tbl[9] = mk(1, 4'b0011, 32'd0, 32'd12345, 0, 4'b0000, 32'd0, 32'd0,
                2, 0, 32'h0, 0, 0, 33);

    codes[0] = 4'b0010; codes[1] = 4'b0110; codes[2] = 4'b0000;
    codes[3] = 4'b0001; codes[4] = 4'b0011; codes[5] = 4'b1010;

    // Reset with both requesters asserting valid: everything must stay low.
    rst_n           = 1'b0;
    bus.rsp_ready_i = 1'b0;
    drive_req(1'b1, junk_op(), 1'b1, junk_op());
    #1;
    check("reset_outputs", 64'({rsp_snapshot(), bus.busy_o}), 64'(0));
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    drive_req(1'b0, junk_op(), 1'b0, junk_op());
    rr_m = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      transact($sformatf("vec%0d", i), tbl[i]);
      $display("vec %0d: id=%0d data=%h err=%0d", i, tbl[i].exp_id, tbl[i].exp_data,
               tbl[i].exp_err);
    end

    // Randomized traffic; grant and result come from the bench's own rules.
    for (int i = 0; i < 40; i++) begin
      t.v0 = 1'($urandom_range(0, 1));
      t.v1 = t.v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int k = 0; k < 2; k++) begin
        o.ctrl = codes[$urandom_range(0, 5)];
        o.a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        o.b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        if (k == 0) t.o0 = o; else t.o1 = o;
      end
      t.exp_id   = (t.v0 && t.v1) ? rr_m : t.v1;
      o          = t.exp_id ? t.o1 : t.o0;
      m          = model(o);
      t.exp_err  = m[32];
      t.exp_data = m[31:0];
      t.exp_lat  = (o.ctrl == 4'b0011) ? 33 : 1;
      t.hold     = $urandom_range(0, 3);
      t.keep     = 1'($urandom_range(0, 1));
      transact($sformatf("rnd%0d", i), t);
      $display("rnd %0d: ctrl=%b id=%0d data=%h err=%0d", i, o.ctrl, t.exp_id,
               t.exp_data, t.exp_err);
    end

    // Reset in the tenth multiply cycle discards the operation.
    o.ctrl = 4'b0011; o.a = 32'h1234; o.b = 32'h5678;
    drive_req(1'b0, junk_op(), 1'b1, o);
    #1;
    check("mulrst_ready1", 64'(bus.req1_ready_o), 64'(1));
    @(posedge clk); #1;
    drive_req(1'b1, junk_op(), 1'b1, junk_op());
    repeat (9) @(posedge clk);
    #2;
    check("mulrst_busy_before", 64'(bus.busy_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mulrst_outputs", 64'({rsp_snapshot(), bus.busy_o}), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive_req(1'b0, junk_op(), 1'b0, junk_op());
    rr_m     = 1'b0;
    bad_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.rsp_valid_o || bus.busy_o) bad_seen = 1'b1;
    end
    check("mulrst_no_response", 64'(bad_seen), 64'(0));
    $display("mulrst: reset during multiply, no response afterwards");

    transact("post_reset_tie", mk(1, 4'b0010, 32'd1, 32'd2, 1, 4'b0010, 32'd9, 32'd9,
                                  0, 0, 32'd3, 0, 0, 1));
    $display("post_reset_tie: id=0 data=00000003");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; all arithmetic in this document is for the default.
REQ-002 Parameter MUL_STEPS, default 32, shift-add iterations per multiply (equals DATA_W).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 req0_valid_i  in  1  requester 0 has an operation pending.
REQ-006 req0_ready_o  out  1  requester 0 accepted this cycle when valid&ready.
REQ-007 req0_data1_i, req0_data2_i  in  32 each  requester 0 operands.
REQ-008 req0_ctrl_i  in  4  requester 0 op code: 0010 add, 0110 sub, 0000 and, 0001 or, 0011 mult.
REQ-009 req1_valid_i, req1_ready_o, req1_data1_i, req1_data2_i, req1_ctrl_i: same as REQ-005..008 for requester 1.
REQ-010 rsp_valid_o  out  1  result available.
REQ-011 rsp_ready_i  in  1  consumer takes result when valid&ready.
REQ-012 rsp_data_o  out  32  result.
REQ-013 rsp_id_o  out  1  requester that issued the result.
REQ-014 rsp_zero_o  out  1  rsp_data_o == 0.
REQ-015 rsp_err_o  out  1  op code was not one of REQ-008.
REQ-016 busy_o  out  1  state != IDLE.

Function
REQ-017 FSM states IDLE, MUL, RESP; only IDLE accepts requests.
REQ-018 In IDLE, grant goes to the sole valid requester; if both valid, to the requester named by round-robin pointer rr.
REQ-019 reqN_ready_o = (state==IDLE) & grant==N, combinational; never both high; both low outside IDLE.
REQ-020 On accept, operands, ctrl and id are captured; rr set to the non-accepted id (i.e. !id).
REQ-021 Single-cycle ops (add, sub, and, or) and unsupported codes: result registered at accept edge; state -> RESP; rsp_valid_o high the next cycle (latency 1).
REQ-022 add/sub wrap modulo 2^32; no carry/overflow output.
REQ-023 Unsupported ctrl: rsp_data_o = 0, rsp_err_o = 1, rsp_zero_o = 1.
REQ-024 mult: state -> MUL; one shift-add step per cycle for MUL_STEPS cycles; result = low 32 bits of product; then -> RESP; rsp_valid_o high 33 cycles after accept edge.
REQ-025 RESP: rsp_* outputs held stable until rsp_valid_o & rsp_ready_i; then -> IDLE; no accept in that same cycle (max throughput one op per 2 cycles).
REQ-026 rsp_ready_i ignored outside RESP; requester inputs ignored outside IDLE.
REQ-027 Valid deasserted before accept is legal; no request is remembered.

Reset
REQ-028 rst_i low asynchronously forces IDLE, rr=0, all outputs 0 (ready outputs 0 while in reset).
REQ-029 Reset mid-MUL or mid-RESP discards the operation; no response produced after reset release.
REQ-030 First grant after reset with both valid goes to requester 0.

Structure
REQ-031 Op-code constants (ADD, SUB, AND, OR, MUL) and FSM state encoding live in shared package alu_pkg, reused by ALU.
REQ-032 Iterative multiplier is sub-module mul_iter (start, operands, done, product_lo); all other logic in alu_sched.

Verification
REQ-033 Only req0: add 5+7 -> rsp_valid cycle after accept, data 12, id 0, zero 0, err 0.
REQ-034 Both valid after reset: req0 sub 3-5, req1 and FFFF0000&0F0F0F0F -> req0 first, data FFFFFFFE; then req1, data 0F0F0000, id 1.
REQ-035 req1 mult 0x10000 x 0x10003 -> rsp_valid 33 cycles after accept, data 0x00030000; ready outputs low throughout.
REQ-036 rsp_ready_i held low 10 cycles in RESP -> outputs stable, no new accept; ready high -> IDLE, next accept one cycle later.
REQ-037 ctrl 1111 -> data 0, err 1, zero 1, latency 1.
REQ-038 rst_i low at MUL cycle 10 -> all outputs 0 immediately; after release no rsp_valid until new request.
